// File: rtl/rvfi_trace_buffer.sv
// RVFI retirement trace buffer: captures retirements into a FIFO and serialises
// each entry as five 32-bit trace words; checks order continuity and halts on in_halt.
module rvfi_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [63:0]              in_order,
  input  logic [31:0]              in_insn,
  input  logic [31:0]              in_pc_rdata,
  input  logic [31:0]              in_pc_wdata,
  input  logic [31:0]              in_rd_wdata,
  input  logic [4:0]               in_rd_addr,
  input  logic                     in_trap,
  input  logic                     in_halt,
  input  logic                     in_intr,
  output logic                     out_valid,
  output logic [31:0]              out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              drop_count,
  output logic                     order_error,
  output logic                     halted
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [15:0] order;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [4:0]  rd_addr;
    logic [31:0] pc_rdata;
    logic [31:0] insn;
    logic [31:0] rd_wdata;
    logic [31:0] pc_wdata;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [2:0]      widx;
  logic [63:0]     expected_order;
  logic            first_seen;
  logic            take, push, pop, drop;

  // A full FIFO still accepts when the head entry retires its last word this cycle
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready & (widx == 3'd4);
  assign take      = in_valid & ~halted;
  assign push      = take & ((count != FULL) | pop);
  assign drop      = take & ~push;
  assign head      = mem[rd_ptr];
  assign out_last  = out_valid & (widx == 3'd4);

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      case (widx)
        3'd0:    out_data = {8'hA5, head.trap, head.halt, head.intr, head.rd_addr, head.order};
        3'd1:    out_data = head.pc_rdata;
        3'd2:    out_data = head.insn;
        3'd3:    out_data = head.rd_wdata;
        default: out_data = head.pc_wdata;
      endcase
    end
  end

  // Storage array carries no reset; validity is tracked by count/pointers
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= '{order: in_order[15:0], trap: in_trap, halt: in_halt, intr: in_intr,
                       rd_addr: in_rd_addr, pc_rdata: in_pc_rdata, insn: in_insn,
                       rd_wdata: in_rd_wdata, pc_wdata: in_pc_wdata};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      widx           <= '0;
      drop_count     <= '0;
      order_error    <= 1'b0;
      halted         <= 1'b0;
      first_seen     <= 1'b0;
      expected_order <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (out_valid & out_ready) widx <= pop ? 3'd0 : widx + 3'd1;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (take) begin
        if (first_seen && in_order != expected_order) order_error <= 1'b1;
        expected_order <= in_order + 64'd1;
        first_seen     <= 1'b1;
        if (in_halt) halted <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Directed bench for rvfi_trace_buffer: word format, overflow/drop, same-cycle
// pop+push when full, order checking, halt, and mid-record reset.
module tb_rvfi_trace_buffer;
  logic        clock, reset;
  logic        in_valid, in_trap, in_halt, in_intr, out_ready;
  logic [63:0] in_order;
  logic [31:0] in_insn, in_pc_rdata, in_pc_wdata, in_rd_wdata;
  logic [4:0]  in_rd_addr;
  logic        out_valid, out_last, order_error, halted;
  logic [31:0] out_data;
  logic [3:0]  count;
  logic [15:0] drop_count;
  int n_chk = 0, n_pass = 0;

  rvfi_trace_buffer #(.DEPTH(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_order(in_order),
    .in_insn(in_insn), .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata),
    .in_rd_wdata(in_rd_wdata), .in_rd_addr(in_rd_addr), .in_trap(in_trap),
    .in_halt(in_halt), .in_intr(in_intr), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .count(count),
    .drop_count(drop_count), .order_error(order_error), .halted(halted));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Stimulus fields are derived from the order number so words can be predicted
  function automatic logic [31:0] expw(input logic [63:0] o, input int k, input logic h);
    case (k)
      0:       return {8'hA5, o[0], h, o[1], o[4:0], o[15:0]};
      1:       return 32'h1000 + (o[31:0] << 2);
      2:       return 32'h13 + (o[31:0] << 7);
      3:       return 32'hD000_0000 + o[31:0];
      default: return 32'h1004 + (o[31:0] << 2);
    endcase
  endfunction

  task automatic drive(input logic [63:0] o, input logic h);
    in_valid = 1'b1; in_order = o; in_halt = h;
    in_trap = o[0]; in_intr = o[1]; in_rd_addr = o[4:0];
    in_pc_rdata = expw(o, 1, h); in_insn = expw(o, 2, h);
    in_rd_wdata = expw(o, 3, h); in_pc_wdata = expw(o, 4, h);
    @(negedge clock);
    in_valid = 1'b0; in_halt = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic drain_entry(input string tag, input logic [63:0] o, input logic h);
    for (int k = 0; k < 5; k++) begin
      chk({tag, "_word"}, out_data, expw(o, k, h));
      chk({tag, "_last"}, out_last, (k == 4));
      @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_order = '0;
    in_insn = '0; in_pc_rdata = '0; in_pc_wdata = '0; in_rd_wdata = '0;
    in_rd_addr = '0; in_trap = 1'b0; in_halt = 1'b0; in_intr = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_oerr", order_error, 0);
    chk("rst_halt", halted, 0);
    do_reset();

    // Single retirement, fixed vector
    out_ready = 1'b1;
    in_valid = 1'b1; in_order = 64'd0; in_pc_rdata = 32'h100; in_insn = 32'h00500093;
    in_rd_addr = 5'd1; in_rd_wdata = 32'd5; in_pc_wdata = 32'h104;
    @(negedge clock);
    in_valid = 1'b0;
    chk("single_count", count, 1);
    begin
      logic [31:0] w [5];
      w = '{32'hA501_0000, 32'h100, 32'h0050_0093, 32'h5, 32'h104};
      for (int k = 0; k < 5; k++) begin
        chk("single_word", out_data, w[k]);
        chk("single_last", out_last, (k == 4));
        @(negedge clock);
      end
    end
    chk("single_empty", count, 0);
    chk("single_nvalid", out_valid, 0);

    // Overflow: 10 retirements into 8 entries
    do_reset();
    for (int i = 0; i < 10; i++) drive(i, 1'b0);
    chk("ovf_count", count, 8);
    chk("ovf_drop", drop_count, 2);
    chk("ovf_oerr", order_error, 0);
    chk("ovf_hold0", out_data, expw(0, 0, 0));
    @(negedge clock);
    chk("ovf_hold1", out_data, expw(0, 0, 0));
    chk("ovf_hold_last", out_last, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) drain_entry("ovf", i, 1'b0);
    chk("ovf_empty", count, 0);
    chk("ovf_nvalid", out_valid, 0);

    // Full FIFO, push lands in the same cycle as the last-word pop
    do_reset();
    for (int i = 0; i < 8; i++) drive(i, 1'b0);
    out_ready = 1'b1;
    repeat (4) @(negedge clock);
    chk("full_idx4_last", out_last, 1);
    drive(8, 1'b0);
    chk("full_count", count, 8);
    chk("full_drop", drop_count, 0);
    chk("full_head", out_data, expw(1, 0, 0));
    for (int i = 1; i < 9; i++) drain_entry("full", i, 1'b0);
    chk("full_empty", count, 0);

    // Order discontinuity is sticky
    do_reset();
    out_ready = 1'b1;
    drive(5, 1'b0);
    drive(6, 1'b0);
    chk("ord_ok", order_error, 0);
    drive(8, 1'b0);
    chk("ord_err", order_error, 1);
    drive(9, 1'b0);
    drive(10, 1'b0);
    chk("ord_sticky", order_error, 1);

    // Halt: later retirements ignored
    do_reset();
    drive(0, 1'b1);
    drive(1, 1'b0);
    drive(2, 1'b0);
    drive(3, 1'b0);
    chk("halt_flag", halted, 1);
    chk("halt_count", count, 1);
    chk("halt_drop", drop_count, 0);
    out_ready = 1'b1;
    drain_entry("halt", 0, 1'b1);
    chk("halt_empty", out_valid, 0);

    // Reset in the middle of a record
    do_reset();
    drive(0, 1'b0);
    drive(1, 1'b0);
    drive(2, 1'b0);
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("mid_w2", out_data, expw(0, 2, 0));
    reset = 1'b0;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_count", count, 0);
    chk("mid_data", out_data, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    chk("mid_post_valid", out_valid, 0);
    chk("mid_post_count", count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
